// File: rtl/arbitro_rolhas_if.sv
// Signal bundle between the cork-magazine arbiter and the capping line:
// line counters, manual switches and restock in; load, grant and stock status out.
interface arbitro_rolhas_if;
  logic [6:0] count_a;
  logic [6:0] count_b;
  logic       manual_a;
  logic       manual_b;
  logic       reposicao;
  logic       load_a;
  logic       load_b;
  logic [6:0] valor_carga;
  logic       grant_a;
  logic       grant_b;
  logic [7:0] estoque;
  logic       alerta_estoque;
  logic       estoque_vazio;
  logic       ocupado;

  modport master (
    output count_a, count_b, manual_a, manual_b, reposicao,
    input  load_a, load_b, valor_carga, grant_a, grant_b,
    input  estoque, alerta_estoque, estoque_vazio, ocupado
  );

  modport slave (
    input  count_a, count_b, manual_a, manual_b, reposicao,
    output load_a, load_b, valor_carga, grant_a, grant_b,
    output estoque, alerta_estoque, estoque_vazio, ocupado
  );
endinterface

// File: rtl/arbitro_rolhas.sv
// Shares one cork magazine between line counters A and B: automatic and manual
// refill requests are arbitrated, and the winner gets a one-cycle load.
module arbitro_rolhas #(
  parameter logic [7:0] CAPACIDADE    = 8'd100,
  parameter logic [7:0] QTD_RECARGA   = 8'd15,
  parameter logic [6:0] LIMITE_MIN    = 7'd5,
  parameter logic [6:0] MAX_CONTADOR  = 7'd99,
  parameter logic [7:0] LIMITE_ALERTA = 8'd20
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  arbitro_rolhas_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALCULA = 2'd1,
    CARGA   = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  estado_t    estado_q;
  logic [7:0] estoque_q, estoque_d;
  logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic       man_prev_a_q, man_prev_b_q;
  logic       rr_q;
  logic       linha_q;
  logic       auto_q;
  logic [7:0] transf_q;
  logic [6:0] valor_q;
  logic       load_a_q, load_b_q, grant_a_q, grant_b_q;

  logic       tem_estoque_s;
  logic       auto_a_s, auto_b_s, man_a_s, man_b_s;
  logic       req_a_s, req_b_s, classe_auto_s;
  logic       tem_vencedor_s, empate_s, vence_b_s;
  logic [6:0] cont_sel_s;
  logic [7:0] transf_s, soma_s, base_s;
  logic [6:0] valor_s;
  logic       subida_a_s, subida_b_s, limpa_a_s, limpa_b_s;

  // Request qualification and winner selection (auto class beats manual, rr_q breaks ties)
  always_comb begin
    tem_estoque_s  = (estoque_q != 8'd0);
    auto_a_s       = (bus.count_a <= LIMITE_MIN) && tem_estoque_s;
    auto_b_s       = (bus.count_b <= LIMITE_MIN) && tem_estoque_s;
    man_a_s        = pend_a_q && (bus.count_a < MAX_CONTADOR) && tem_estoque_s;
    man_b_s        = pend_b_q && (bus.count_b < MAX_CONTADOR) && tem_estoque_s;
    classe_auto_s  = auto_a_s || auto_b_s;
    if (classe_auto_s) begin
      req_a_s = auto_a_s;
      req_b_s = auto_b_s;
    end else begin
      req_a_s = man_a_s;
      req_b_s = man_b_s;
    end
    tem_vencedor_s = req_a_s || req_b_s;
    empate_s       = req_a_s && req_b_s;
    if (empate_s) begin
      vence_b_s = rr_q;
    end else begin
      vence_b_s = req_b_s;
    end
  end

  // Load value: 8-bit sum so an auto refill can saturate cleanly at MAX_CONTADOR
  always_comb begin
    cont_sel_s = linha_q ? bus.count_b : bus.count_a;
    if (!auto_q) begin
      transf_s = 8'd1;
    end else if (estoque_q < QTD_RECARGA) begin
      transf_s = estoque_q;
    end else begin
      transf_s = QTD_RECARGA;
    end
    soma_s = {1'b0, cont_sel_s} + transf_s;
    if (auto_q && (soma_s > {1'b0, MAX_CONTADOR})) begin
      valor_s = MAX_CONTADOR;
    end else begin
      valor_s = soma_s[6:0];
    end
  end

  // Manual pending flags and stock next-state; an edge on an already pending line is absorbed
  always_comb begin
    subida_a_s = bus.manual_a && !man_prev_a_q;
    subida_b_s = bus.manual_b && !man_prev_b_q;
    limpa_a_s  = ((estado_q == CARGA) && !auto_q && !linha_q) ||
                 ((estado_q == IDLE) && pend_a_q && (bus.count_a >= MAX_CONTADOR) && tem_estoque_s);
    limpa_b_s  = ((estado_q == CARGA) && !auto_q && linha_q) ||
                 ((estado_q == IDLE) && pend_b_q && (bus.count_b >= MAX_CONTADOR) && tem_estoque_s);
    pend_a_d   = (pend_a_q || subida_a_s) && !limpa_a_s;
    pend_b_d   = (pend_b_q || subida_b_s) && !limpa_b_s;
    base_s     = bus.reposicao ? CAPACIDADE : estoque_q;
    estoque_d  = (estado_q == CARGA) ? (base_s - transf_q) : base_s;
  end

  // Service sequencer with registered strobes, grants and load value
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      estado_q     <= IDLE;
      estoque_q    <= CAPACIDADE;
      pend_a_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      man_prev_a_q <= bus.manual_a;
      man_prev_b_q <= bus.manual_b;
      rr_q         <= 1'b0;
      linha_q      <= 1'b0;
      auto_q       <= 1'b0;
      transf_q     <= 8'd0;
      valor_q      <= 7'd0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
    end else begin
      man_prev_a_q <= bus.manual_a;
      man_prev_b_q <= bus.manual_b;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      estoque_q    <= estoque_d;
      case (estado_q)
        IDLE: begin
          if (tem_vencedor_s) begin
            linha_q   <= vence_b_s;
            auto_q    <= classe_auto_s;
            grant_a_q <= !vence_b_s;
            grant_b_q <= vence_b_s;
            if (empate_s) begin
              rr_q <= !vence_b_s;
            end
            estado_q  <= CALCULA;
          end
        end
        CALCULA: begin
          transf_q <= transf_s;
          valor_q  <= valor_s;
          load_a_q <= !linha_q;
          load_b_q <= linha_q;
          estado_q <= CARGA;
        end
        CARGA: begin
          load_a_q <= 1'b0;
          load_b_q <= 1'b0;
          estado_q <= ESPERA;
        end
        ESPERA: begin
          grant_a_q <= 1'b0;
          grant_b_q <= 1'b0;
          estado_q  <= IDLE;
        end
        default: begin
          load_a_q  <= 1'b0;
          load_b_q  <= 1'b0;
          grant_a_q <= 1'b0;
          grant_b_q <= 1'b0;
          estado_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.load_a         = load_a_q;
  assign bus.load_b         = load_b_q;
  assign bus.valor_carga    = valor_q;
  assign bus.grant_a        = grant_a_q;
  assign bus.grant_b        = grant_b_q;
  assign bus.estoque        = estoque_q;
  assign bus.alerta_estoque = (estoque_q <= LIMITE_ALERTA);
  assign bus.estoque_vazio  = (estoque_q == 8'd0);
  assign bus.ocupado        = (estado_q != IDLE);

endmodule

// File: tb/tb_arbitro_rolhas.sv
// Bench for arbitro_rolhas: directed scenarios plus random traffic, all compared
// every cycle against a transaction-level model of the magazine service.
module tb_arbitro_rolhas;

  localparam int CAP = 100;
  localparam int QTD = 15;
  localparam int MIN = 5;
  localparam int MAXC = 99;
  localparam int ALERTA = 20;

  logic clock_i;
  logic reset_ni;
  arbitro_rolhas_if bus ();

  arbitro_rolhas u_dut (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus
  int cnt[2];
  bit man[2];
  bit rep;

  // model state
  int m_phase;
  int m_stock;
  int m_transf;
  int m_valor;
  int m_line;
  bit m_auto;
  bit m_rr;
  bit m_pend[2];
  bit m_prev[2];
  bit m_load[2];
  bit m_grant[2];

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  assign bus.count_a   = 7'(cnt[0]);
  assign bus.count_b   = 7'(cnt[1]);
  assign bus.manual_a  = man[0];
  assign bus.manual_b  = man[1];
  assign bus.reposicao = rep;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge of the service rules, from the reference point of the magazine owner
  task automatic model_step();
    bit nova_pend[2];
    bit ra[2];
    bit rm[2];
    bit req[2];
    int s0;
    int w;
    s0 = m_stock;
    if (!reset_ni) begin
      m_phase = 0; m_stock = CAP; m_rr = 0; m_valor = 0; m_transf = 0;
      m_line = 0; m_auto = 0;
      for (int x = 0; x < 2; x++) begin
        m_pend[x] = 0; m_prev[x] = man[x]; m_load[x] = 0; m_grant[x] = 0;
      end
      return;
    end
    for (int x = 0; x < 2; x++) begin
      nova_pend[x] = m_pend[x] | (man[x] & !m_prev[x]);
      m_prev[x] = man[x];
    end
    if (rep) m_stock = CAP;
    case (m_phase)
      0: begin
        for (int x = 0; x < 2; x++) begin
          ra[x] = (cnt[x] <= MIN) && (s0 > 0);
          rm[x] = m_pend[x] && (cnt[x] < MAXC) && (s0 > 0);
          if (m_pend[x] && cnt[x] >= MAXC && s0 > 0) nova_pend[x] = 0;
        end
        m_auto = ra[0] | ra[1];
        for (int x = 0; x < 2; x++) req[x] = m_auto ? ra[x] : rm[x];
        if (req[0] || req[1]) begin
          if (req[0] && req[1]) begin
            w = m_rr ? 1 : 0;
            m_rr = (w == 0);
          end else begin
            w = req[1] ? 1 : 0;
          end
          m_line = w;
          m_grant[w] = 1;
          m_phase = 1;
        end
      end
      1: begin
        m_transf = m_auto ? imin(QTD, s0) : 1;
        m_valor  = m_auto ? imin(cnt[m_line] + m_transf, MAXC) : (cnt[m_line] + 1) % 128;
        m_load[m_line] = 1;
        m_phase = 2;
      end
      2: begin
        m_load[0] = 0; m_load[1] = 0;
        m_stock = (rep ? CAP : s0) - m_transf;
        if (!m_auto) nova_pend[m_line] = 0;
        m_phase = 3;
      end
      default: begin
        m_grant[0] = 0; m_grant[1] = 0;
        m_phase = 0;
      end
    endcase
    for (int x = 0; x < 2; x++) m_pend[x] = nova_pend[x];
  endtask

  task automatic compare_all();
    check("load_a", bus.load_a, m_load[0]);
    check("load_b", bus.load_b, m_load[1]);
    check("grant_a", bus.grant_a, m_grant[0]);
    check("grant_b", bus.grant_b, m_grant[1]);
    check("valor_carga", bus.valor_carga, m_valor);
    check("estoque", bus.estoque, m_stock);
    check("alerta", bus.alerta_estoque, (m_stock <= ALERTA) ? 1 : 0);
    check("vazio", bus.estoque_vazio, (m_stock == 0) ? 1 : 0);
    check("ocupado", bus.ocupado, (m_phase != 0) ? 1 : 0);
    check("load_excl", bus.load_a & bus.load_b, 0);
  endtask

  // One cycle: edge, model update, line counters absorb last cycle's load, compare on falling edge
  task automatic tick();
    bit ld[2];
    int vl;
    @(posedge clock_i);
    ld[0] = m_load[0]; ld[1] = m_load[1]; vl = m_valor;
    model_step();
    #1;
    for (int x = 0; x < 2; x++) if (ld[x]) cnt[x] = vl;
    @(negedge clock_i);
    compare_all();
  endtask

  task automatic wait_load(input int line, input int max, output bit found, output int n);
    found = 0;
    n = 0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      n++;
      if (((line == 0) ? bus.load_a : bus.load_b) == 1'b1) found = 1;
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    tick();
    tick();
    reset_ni = 1'b1;
  endtask

  bit f;
  int n;

  initial begin
    reset_ni = 1'b0;
    rep = 0; man[0] = 0; man[1] = 0; cnt[0] = 50; cnt[1] = 50;
    m_phase = 0; m_stock = CAP;
    do_reset();
    check("rst_estoque", bus.estoque, CAP);
    check("rst_ocupado", bus.ocupado, 0);
    check("rst_valor", bus.valor_carga, 0);

    // single auto request on A
    cnt[0] = 3;
    wait_load(0, 6, f, n);
    check("a_found", f, 1);
    check("a_latency", n, 2);
    check("a_valor", bus.valor_carga, 18);
    check("a_grant", bus.grant_a, 1);
    tick(); tick();
    check("a_estoque", bus.estoque, 85);

    // simultaneous tie: A first, B four cycles later, then B wins the next tie
    do_reset();
    cnt[0] = 2; cnt[1] = 2;
    wait_load(0, 6, f, n);
    check("tie_a_found", f, 1);
    check("tie_a_valor", bus.valor_carga, 17);
    wait_load(1, 8, f, n);
    check("tie_b_found", f, 1);
    check("tie_b_gap", n, 4);
    check("tie_b_valor", bus.valor_carga, 17);
    tick(); tick();
    check("tie_estoque", bus.estoque, 70);
    cnt[0] = 2; cnt[1] = 2;
    wait_load(1, 8, f, n);
    check("tie2_b_first", n, 2);
    repeat (8) tick();

    // drain to 7 then to 0, blocked until restock
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cnt[0] = 0;
      wait_load(0, 6, f, n);
      check("drain_auto", f, 1);
      repeat (2) tick();
    end
    for (int k = 0; k < 3; k++) begin
      man[1] = 1;
      wait_load(1, 8, f, n);
      check("drain_man", f, 1);
      man[1] = 0;
      repeat (2) tick();
    end
    check("drain_estoque7", bus.estoque, 7);
    cnt[0] = 4;
    wait_load(0, 6, f, n);
    check("drain_valor11", bus.valor_carga, 11);
    tick();
    check("drain_estoque0", bus.estoque, 0);
    check("drain_vazio", bus.estoque_vazio, 1);
    tick();
    cnt[0] = 0;
    wait_load(0, 10, f, n);
    check("empty_no_load", f, 0);
    check("empty_idle", bus.ocupado, 0);
    rep = 1; tick(); rep = 0;
    check("restock", bus.estoque, CAP);
    wait_load(0, 6, f, n);
    check("resume_load", f, 1);
    check("resume_valor", bus.valor_carga, 15);
    repeat (2) tick();

    // count changes to 90 before CALCULA -> saturated; manual at 99 dropped
    do_reset();
    cnt[0] = 3;
    tick();
    cnt[0] = 90;
    tick();
    check("sat_load", bus.load_a, 1);
    check("sat_valor", bus.valor_carga, 99);
    tick();
    check("sat_estoque", bus.estoque, 85);
    tick();
    man[0] = 1;
    wait_load(0, 10, f, n);
    check("drop_no_load", f, 0);
    man[0] = 0;

    // auto A beats manual B; second B edge while pending gives a single load
    do_reset();
    cnt[0] = 1; cnt[1] = 40; man[1] = 1;
    tick();
    check("prio_grant_a", bus.grant_a, 1);
    man[1] = 0; tick();
    man[1] = 1; tick();
    wait_load(1, 10, f, n);
    check("man_b_found", f, 1);
    check("man_b_valor", bus.valor_carga, 41);
    tick(); tick();
    check("man_b_estoque", bus.estoque, 84);
    wait_load(1, 12, f, n);
    check("man_b_single", f, 0);

    // reset during CALCULA aborts
    do_reset();
    cnt[0] = 3;
    tick();
    check("calc_grant", bus.grant_a, 1);
    reset_ni = 1'b0; cnt[0] = 50;
    tick();
    check("abort_load", bus.load_a, 0);
    check("abort_grant", bus.grant_a, 0);
    check("abort_estoque", bus.estoque, CAP);
    check("abort_ocupado", bus.ocupado, 0);
    reset_ni = 1'b1;
    repeat (4) tick();

    // restock coinciding with CARGA
    cnt[0] = 3;
    wait_load(0, 6, f, n);
    repeat (2) tick();
    cnt[0] = 3;
    wait_load(0, 6, f, n);
    check("rep_carga_found", f, 1);
    rep = 1; tick(); rep = 0;
    check("rep_carga_estoque", bus.estoque, 85);
    repeat (2) tick();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(0, 7) == 0) man[x] = !man[x];
        if ($urandom_range(0, 5) == 0 && cnt[x] > 0) cnt[x] = cnt[x] - 1;
        if ($urandom_range(0, 39) == 0) cnt[x] = int'($urandom_range(0, 99));
      end
      rep = ($urandom_range(0, 47) == 0);
      reset_ni = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rolhas.md
Name: arbitro_rolhas

Overview:
Controller that shares one cork magazine between two capping-line counters, A and B. It watches both counters and raises refill requests automatically. It also accepts a manual one-cork request per line. One request at a time wins arbitration, and the block then drives a one-cycle load with the computed value into the winning counter. It owns the magazine stock register and accepts warehouse restock pulses.

Parameters:
CAPACIDADE, 100, magazine stock after reset/restock (8-bit)
QTD_RECARGA, 15, corks moved per automatic refill
LIMITE_MIN, 5, counter value at or below which an automatic refill is requested
MAX_CONTADOR, 99, saturation value of each line counter
LIMITE_ALERTA, 20, stock at or below which ALERTA_ESTOQUE asserts

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-low reset
COUNT_A  in  7  current value of line A counter
COUNT_B  in  7  current value of line B counter
MANUAL_A  in  1  manual add switch, line A (level; rising edge = request)
MANUAL_B  in  1  manual add switch, line B
REPOSICAO  in  1  warehouse restock, one-cycle pulse
LOAD_A  out  1  one-cycle load strobe to counter A
LOAD_B  out  1  one-cycle load strobe to counter B
VALOR_CARGA  out  7  load value, shared by both counters
GRANT_A  out  1  line A currently being served
GRANT_B  out  1  line B currently being served
ESTOQUE  out  8  magazine stock
ALERTA_ESTOQUE  out  1  stock is low
ESTOQUE_VAZIO  out  1  stock is zero
OCUPADO  out  1  state is not IDLE

Behaviour:
- Reset (RESET=0 at a CLOCK edge):
  - state IDLE; ESTOQUE=CAPACIDADE
  - LOAD_x=0, GRANT_x=0, VALOR_CARGA=0, OCUPADO=0
  - manual pending flags cleared; edge-detect registers loaded with the current MANUAL_x; round-robin pointer set to A
  - Reset mid-operation aborts any grant; no load is issued and stock is not decremented.
- Flags, derived from registered ESTOQUE:
  - ALERTA_ESTOQUE = (ESTOQUE <= LIMITE_ALERTA)
  - ESTOQUE_VAZIO = (ESTOQUE == 0)
  - Both are 0 after reset.
- Manual capture, every cycle in every state:
  - A rising edge on MANUAL_x sets pend_x.
  - An edge while pend_x is already set is discarded (no counting).
- Request conditions:
  - auto_x = (COUNT_x <= LIMITE_MIN) && (ESTOQUE > 0)
  - man_x = pend_x && (COUNT_x < MAX_CONTADOR) && (ESTOQUE > 0)
  - A pend_x that fails only the COUNT test in IDLE is cleared (dropped).
  - A pend_x that fails only the stock test is held.
- Arbitration, IDLE only:
  - Any auto request beats any manual request.
  - Within the same class, a single requester wins.
  - If both lines request in the same class, the line the round-robin pointer favours wins, and the pointer then moves to the other line.
- FSM: IDLE -> CALCULA -> CARGA -> ESPERA -> IDLE.
  - IDLE: if a winner exists, latch line id and kind (auto/manual), then go to CALCULA.
  - CALCULA:
    - Latch COUNT of the winner.
    - Auto: transf = min(QTD_RECARGA, ESTOQUE); VALOR_CARGA = min(COUNT + transf, MAX_CONTADOR). Compute the sum in 8 bits.
    - Manual: transf = 1; VALOR_CARGA = COUNT + 1.
    - GRANT of the winner asserts here.
  - CARGA:
    - LOAD of the winner = 1 for exactly this cycle.
    - ESTOQUE <= ESTOQUE - transf.
    - If manual, clear pend of the winner.
  - ESPERA: one cycle for the counter to absorb the load. GRANT deasserts on exit.
- Timing: request seen in IDLE at edge t -> GRANT from t+1 -> LOAD high during cycle t+2 -> IDLE again at t+4. Worst-case service of a second line is 4 cycles later.
- VALOR_CARGA holds its last value outside CARGA. LOAD_A and LOAD_B are never high together.
- REPOSICAO:
  - In any state other than CARGA: ESTOQUE <= CAPACIDADE.
  - Coinciding with CARGA: ESTOQUE <= CAPACIDADE - transf.
- Stock never underflows: transf <= ESTOQUE is guaranteed by the request conditions.
- OCUPADO = (state != IDLE).

Test Plan:
- Reset, then COUNT_A=3, COUNT_B=50 -> GRANT_A from cycle t+1; LOAD_A for one cycle with VALOR_CARGA=18; ESTOQUE 100->85; LOAD_B never asserts.
- Both counts 2 at the same edge -> A served first (VALOR=17, ESTOQUE=85), then B (LOAD_B 4 cycles later, VALOR=17, ESTOQUE=70). Next simultaneous request is served B first.
- ESTOQUE driven to 7 with COUNT_A=4 -> VALOR_CARGA=11, ESTOQUE=0, ESTOQUE_VAZIO=1. A further auto request produces no grant until a REPOSICAO pulse, after which ESTOQUE=100 and service resumes.
- COUNT_A=90, auto refill -> VALOR_CARGA=99 (saturated), ESTOQUE decrements by 15. MANUAL_A edge with COUNT_A=99 -> request dropped, no LOAD_A.
- MANUAL_B edge with COUNT_B=40 while COUNT_A=1 -> auto A served first; B then gets VALOR_CARGA=41 and ESTOQUE drops by 1. A second MANUAL_B edge while pend_B is set yields only one load.
- RESET low during CALCULA -> no LOAD, ESTOQUE=100, all outputs 0. REPOSICAO during CARGA with transf=15 -> ESTOQUE=85.
